izh_array: RTL and testbench
============================

// Module: izh_array
// PURPOSE
//   Time-multiplexed array of N_NEURONS Izhikevich neurons sharing one fixed-point datapath.
//   Each neuron keeps its own v/u state and a host-written input current.
//   One `tick` advances every neuron by one Euler step; fired neurons are reported as spike
//   events plus a spike vector. Successor to the single-neuron izh core behind the TT top.
// PARAMETERS
//   N_NEURONS 8      neuron count (>=2); AW = $clog2(N_NEURONS) localparam
//   WIDTH     16     signed state width of v and u
//   FRAC      4      fractional bits of v, u (1 LSB = 2^-FRAC mV)
//   A_SH      6      recovery rate a = 2^-A_SH (~0.02)
//   B_SH      2      coupling b = 2^-B_SH (0.25)
//   DT_SH     0      step size dt = 2^-DT_SH ms
//   C_RST     -1040  post-spike v, and reset v (-65 mV << FRAC)
//   D_INC     128    post-spike u increment (8 << FRAC)
//   V_PEAK    480    spike threshold (30 mV << FRAC)
// PORTS
//   clk          in   1      clock
//   rst_n        in   1      asynchronous reset, active low
//   tick         in   1      start one update step of all neurons
//   cur_we       in   1      current-register write strobe
//   cur_addr     in   AW     neuron index for write
//   cur_data     in   8      unsigned input current, mV/ms integer
//   mon_addr     in   AW     monitor select
//   mon_v        out  WIDTH  registered v[mon_addr], 1-cycle latency
//   spike_valid  out  1      1-cycle pulse: neuron spike_id fired this step
//   spike_id     out  AW     index of firing neuron
//   spike_vec    out  N      fired flags of last completed step
//   busy         out  1      step in progress
//   done         out  1      1-cycle pulse at step completion
//   overrun      out  1      sticky: tick arrived while busy
// BEHAVIOUR
// - Reset: all v = C_RST, all u = C_RST>>>B_SH, all currents 0, FSM IDLE.
//   Outputs 0 except mon_v, which shows C_RST from the first edge after release.
//   Reset mid-step aborts the step; no partial spike or done is emitted.
// - FSM: IDLE -(tick)-> LOAD -> CALC -> STORE -> LOAD of next idx, or IDLE after idx N-1.
//   3 cycles per neuron; busy high for exactly 3*N cycles. The neuron k STORE edge is
//   cycle 3k+3 after the tick edge. done pulses and spike_vec updates on the last STORE edge.
// - tick while busy is ignored and sets overrun. cur_we is accepted in any state.
//   LOAD samples the current value held before a same-cycle write, so that write takes
//   effect on the next step.
// - Arithmetic in CALC: signed, 2*WIDTH+4 internal bits, arithmetic shifts.
//     p = (v*v)>>>FRAC;  sq = (p>>>5)+(p>>>7)          (0.039 v^2)
//     I = cur_data<<FRAC
//     dv = sq + 5v + (140<<FRAC) - u + I;   vn = v + (dv>>>DT_SH)
//     un = u + (((v>>>B_SH) - u)>>>A_SH)   (uses old v)
// - STORE: if vn >= V_PEAK: v=C_RST, u=sat(un+D_INC), spike_valid=1, spike_id=idx,
//   vec bit set. Else v=sat(vn), u=sat(un). sat clamps to the signed WIDTH range.
// - spike_valid and spike_id stay 0 in cycles with no spike.
// CONFIGURATION
//   IZH_NOISE_EN defined: 16-bit Galois LFSR (taps 16,14,13,11, seed 16'hACE1) steps once
//   per CALC, and I = (cur_data + lfsr[3:0])<<FRAC. Reset reloads the seed.
//   IZH_NOISE_EN undefined: no LFSR is present and I = cur_data<<FRAC exactly.
// TESTING
//   1 Reset, sweep mon_addr 0..7 -> mon_v = -1040 for every index; all outputs 0; busy 0.
//   2 All currents 0, one tick -> busy for 24 cycles; done at cycle 24;
//     every mon_v = -1100; no spike_valid.
//   3 cur_data=255 to neuron 3, tick -> spike_valid at cycle 12 with spike_id=3;
//     spike_vec = 8'b0000_1000; mon_v[3] = -1040; the other neurons read -1100.
//   4 tick again at cycle 5 of a step -> ignored; overrun=1 and stays 1 until reset;
//     step length unchanged.
//   5 rst_n low at cycle 10 of a step -> state back to reset values; no done;
//     the next tick runs a clean 24-cycle step.
//   6 IZH_NOISE_EN, currents 0, 10 ticks -> bit-exact against the LFSR reference model;
//     without the macro, results match scenario 2 iterated 10 times.

Source files
------------

// File: rtl/izh_array.sv
// izh_array: N_NEURONS Izhikevich neurons sharing one fixed-point Euler datapath, stepped on `tick`.
// Build macro IZH_NOISE_EN adds a 16-bit Galois LFSR noise term to each neuron's input current.
module izh_array #(
    parameter int N_NEURONS = 8,
    parameter int WIDTH     = 16,
    parameter int FRAC      = 4,
    parameter int A_SH      = 6,
    parameter int B_SH      = 2,
    parameter int DT_SH     = 0,
    parameter int C_RST     = -1040,
    parameter int D_INC     = 128,
    parameter int V_PEAK    = 480,
    localparam int AW       = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 cur_we,
    input  logic [AW-1:0]        cur_addr,
    input  logic [7:0]           cur_data,
    input  logic [AW-1:0]        mon_addr,
    output logic [WIDTH-1:0]     mon_v,
    output logic                 spike_valid,
    output logic [AW-1:0]        spike_id,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int IW = 2*WIDTH + 4;

    localparam logic signed [WIDTH-1:0] C_RST_W = WIDTH'(C_RST);
    localparam logic signed [WIDTH-1:0] U_RST_W = C_RST_W >>> B_SH;
    localparam logic signed [IW-1:0]    K140_X  = IW'(140) <<< FRAC;
    localparam logic signed [IW-1:0]    PEAK_X  = IW'(V_PEAK);
    localparam logic signed [IW-1:0]    DINC_X  = IW'(D_INC);
    localparam logic signed [IW-1:0]    SMAX_X  = {{(IW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0]    SMIN_X  = {{(IW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CALC  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] x);
        logic signed [WIDTH-1:0] r;
        if (x > SMAX_X) begin
            r = SMAX_X[WIDTH-1:0];
        end else if (x < SMIN_X) begin
            r = SMIN_X[WIDTH-1:0];
        end else begin
            r = x[WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [IW-1:0] sx(input logic signed [WIDTH-1:0] x);
        return {{(IW-WIDTH){x[WIDTH-1]}}, x};
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [AW-1:0]           idx_r;
    logic signed [WIDTH-1:0] v_mem_r   [N_NEURONS];
    logic signed [WIDTH-1:0] u_mem_r   [N_NEURONS];
    logic [7:0]              cur_mem_r [N_NEURONS];
    logic signed [WIDTH-1:0] v_ld_r;
    logic signed [WIDTH-1:0] u_ld_r;
    logic [7:0]              cur_ld_r;
    logic signed [IW-1:0]    vn_r;
    logic signed [IW-1:0]    un_r;
    logic [WIDTH-1:0]        mon_v_r;
    logic                    spike_valid_r;
    logic [AW-1:0]           spike_id_r;
    logic [N_NEURONS-1:0]    spike_vec_r;
    logic [N_NEURONS-1:0]    vec_acc_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    overrun_r;

    logic                    start_s;
    logic                    ld_s;
    logic                    calc_s;
    logic                    st_s;
    logic                    ign_s;
    logic                    last_s;
    logic                    fin_s;
    logic                    fire_s;
    logic [N_NEURONS-1:0]    bit_s;
    logic [8:0]              cur_eff_s;
    logic signed [IW-1:0]    v_x_s;
    logic signed [IW-1:0]    u_x_s;
    logic signed [IW-1:0]    p_s;
    logic signed [IW-1:0]    sq_s;
    logic signed [IW-1:0]    i_s;
    logic signed [IW-1:0]    dv_s;
    logic signed [IW-1:0]    vn_s;
    logic signed [IW-1:0]    un_s;
    logic signed [WIDTH-1:0] v_st_s;
    logic signed [WIDTH-1:0] u_st_s;

    assign last_s = (idx_r == AW'(N_NEURONS-1));
    assign fin_s  = st_s & last_s;
    assign bit_s  = {{(N_NEURONS-1){1'b0}}, 1'b1} << idx_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: LOAD/CALC/STORE per neuron, back to IDLE after the last index
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (tick) state_nx_s = S_LOAD;
                else      state_nx_s = S_IDLE;
            end
            S_LOAD:  state_nx_s = S_CALC;
            S_CALC:  state_nx_s = S_STORE;
            S_STORE: begin
                if (last_s) state_nx_s = S_IDLE;
                else        state_nx_s = S_LOAD;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // FSM outputs: per-phase datapath strobes and ignored-tick detection
    always_comb begin
        start_s = 1'b0;
        ld_s    = 1'b0;
        calc_s  = 1'b0;
        st_s    = 1'b0;
        ign_s   = 1'b0;
        case (state_r)
            S_IDLE:  start_s = tick;
            S_LOAD:  begin ld_s   = 1'b1; ign_s = tick; end
            S_CALC:  begin calc_s = 1'b1; ign_s = tick; end
            S_STORE: begin st_s   = 1'b1; ign_s = tick; end
            default: begin
                start_s = 1'b0;
                ign_s   = 1'b0;
            end
        endcase
    end

`ifdef IZH_NOISE_EN
    logic [15:0] lfsr_r;

    // Galois LFSR (taps 16,14,13,11), advanced once per CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 16'hACE1;
        end else if (calc_s) begin
            lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign cur_eff_s = {1'b0, cur_ld_r} + {5'b0_0000, lfsr_r[3:0]};
`else
    assign cur_eff_s = {1'b0, cur_ld_r};
`endif

    // Euler step on the loaded neuron; recovery update uses the pre-step v
    always_comb begin
        v_x_s = sx(v_ld_r);
        u_x_s = sx(u_ld_r);
        p_s   = (v_x_s * v_x_s) >>> FRAC;
        sq_s  = (p_s >>> 5) + (p_s >>> 7);
        i_s   = $signed({{(IW-9){1'b0}}, cur_eff_s}) <<< FRAC;
        dv_s  = sq_s + (v_x_s <<< 2) + v_x_s + K140_X - u_x_s + i_s;
        vn_s  = v_x_s + (dv_s >>> DT_SH);
        un_s  = u_x_s + (((v_x_s >>> B_SH) - u_x_s) >>> A_SH);
    end

    // Spike decision and saturated write-back values
    always_comb begin
        fire_s = (vn_r >= PEAK_X);
        if (fire_s) begin
            v_st_s = C_RST_W;
            u_st_s = sat(un_r + DINC_X);
        end else begin
            v_st_s = sat(vn_r);
            u_st_s = sat(un_r);
        end
    end

    // Sequencing: neuron index, busy/done and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r     <= {AW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (start_s) begin
                idx_r <= {AW{1'b0}};
            end else if (st_s && !last_s) begin
                idx_r <= idx_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                idx_r <= idx_r;
            end
            if (start_s)    busy_r <= 1'b1;
            else if (fin_s) busy_r <= 1'b0;
            else            busy_r <= busy_r;
            done_r    <= fin_s;
            overrun_r <= overrun_r | ign_s;
        end
    end

    // Pipeline registers: LOAD snapshot (pre-write current) and CALC results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_ld_r   <= C_RST_W;
            u_ld_r   <= U_RST_W;
            cur_ld_r <= 8'd0;
            vn_r     <= {IW{1'b0}};
            un_r     <= {IW{1'b0}};
        end else begin
            if (ld_s) begin
                v_ld_r   <= v_mem_r[idx_r];
                u_ld_r   <= u_mem_r[idx_r];
                cur_ld_r <= cur_mem_r[idx_r];
            end else begin
                v_ld_r   <= v_ld_r;
                u_ld_r   <= u_ld_r;
                cur_ld_r <= cur_ld_r;
            end
            if (calc_s) begin
                vn_r <= vn_s;
                un_r <= un_s;
            end else begin
                vn_r <= vn_r;
                un_r <= un_r;
            end
        end
    end

    // Per-neuron state and host-written currents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem_r[i]   <= C_RST_W;
                u_mem_r[i]   <= U_RST_W;
                cur_mem_r[i] <= 8'd0;
            end
        end else begin
            if (cur_we) cur_mem_r[cur_addr] <= cur_data;
            if (st_s) begin
                v_mem_r[idx_r] <= v_st_s;
                u_mem_r[idx_r] <= u_st_s;
            end
        end
    end

    // Spike event, accumulated fire flags and published spike vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_valid_r <= 1'b0;
            spike_id_r    <= {AW{1'b0}};
            vec_acc_r     <= {N_NEURONS{1'b0}};
            spike_vec_r   <= {N_NEURONS{1'b0}};
        end else begin
            spike_valid_r <= st_s & fire_s;
            spike_id_r    <= (st_s && fire_s) ? idx_r : {AW{1'b0}};
            if (start_s) begin
                vec_acc_r <= {N_NEURONS{1'b0}};
            end else if (st_s && fire_s) begin
                vec_acc_r <= vec_acc_r | bit_s;
            end else begin
                vec_acc_r <= vec_acc_r;
            end
            if (fin_s) spike_vec_r <= vec_acc_r | (fire_s ? bit_s : {N_NEURONS{1'b0}});
            else       spike_vec_r <= spike_vec_r;
        end
    end

    // Monitor port: one-cycle registered view of v[mon_addr]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_v_r <= C_RST_W;
        end else begin
            mon_v_r <= v_mem_r[mon_addr];
        end
    end

    assign mon_v       = mon_v_r;
    assign spike_valid = spike_valid_r;
    assign spike_id    = spike_id_r;
    assign spike_vec   = spike_vec_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_izh_array.sv
// tb_izh_array: directed, table-driven bench for izh_array (default build, no noise).
module tb_izh_array;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        cur_we;
    logic [2:0]  cur_addr;
    logic [7:0]  cur_data;
    logic [2:0]  mon_addr;
    logic [15:0] mon_v;
    logic        spike_valid;
    logic [2:0]  spike_id;
    logic [7:0]  spike_vec;
    logic        busy;
    logic        done;
    logic        overrun;

    izh_array dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .cur_we(cur_we), .cur_addr(cur_addr),
        .cur_data(cur_data), .mon_addr(mon_addr), .mon_v(mon_v), .spike_valid(spike_valid),
        .spike_id(spike_id), .spike_vec(spike_vec), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]         addr;
        logic [7:0]         cur;
        logic               exp_spike;
        logic signed [15:0] exp_v;
    } vec_t;

    vec_t tbl [6];
    int   checks = 0;
    int   errors = 0;
    int   idle_id_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; cur_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr_cur(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cur_we = 1'b1; cur_addr = a; cur_data = d;
        @(negedge clk);
        cur_we = 1'b0;
    endtask

    task automatic read_v(input logic [2:0] a, output longint v);
        @(negedge clk);
        mon_addr = a;
        @(posedge clk);
        #1 v = longint'($signed(mon_v));
    endtask

    // One tick, then 40 sampled cycles (c = edges after the tick edge) with optional injections
    task automatic run_step(input int inj_c, input int wr_c, input logic [2:0] wa,
                            input logic [7:0] wd, input int rst_c,
                            output int bc, output int dc, output int sc, output int scyc,
                            output logic [2:0] sid);
        bc = 0; dc = -1; sc = 0; scyc = -1; sid = 3'd0;
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy) bc++;
            if (done && dc < 0) dc = c;
            if (spike_valid) begin
                sc++; scyc = c; sid = spike_id;
            end else if (spike_id != 3'd0) begin
                idle_id_bad++;
            end
            tick     = (c == inj_c - 1);
            cur_we   = (c == wr_c - 1);
            cur_addr = wa;
            cur_data = wd;
            if (rst_c >= 0) rst_n = !(c >= rst_c && c < rst_c + 2);
        end
        tick = 1'b0; cur_we = 1'b0; rst_n = 1'b1;
    endtask

    task automatic model_sat(inout longint x);
        if (x > 32767) x = 32767;
        else if (x < -32768) x = -32768;
    endtask

    task automatic model_step(inout longint v, inout longint u, input int cur);
        longint p, sq, dv, vn, un;
        p  = (v * v) >>> 4;
        sq = (p >>> 5) + (p >>> 7);
        dv = sq + 5 * v + 2240 - u + longint'(cur) * 16;
        vn = v + dv;
        un = u + (((v >>> 2) - u) >>> 6);
        if (vn >= 480) begin
            v = -1040; u = un + 128; model_sat(u);
        end else begin
            v = vn; model_sat(v); u = un; model_sat(u);
        end
    endtask

    initial begin
        int bc, dc, sc, scyc;
        logic [2:0] sid;
        longint rv, mv, mu;

        tbl[0] = '{3'd3, 8'd0,   1'b0, -16'sd1100};
        tbl[1] = '{3'd3, 8'd255, 1'b1, -16'sd1040};
        tbl[2] = '{3'd0, 8'd99,  1'b1, -16'sd1040};
        tbl[3] = '{3'd7, 8'd98,  1'b0,  16'sd468};
        tbl[4] = '{3'd5, 8'd10,  1'b0, -16'sd940};
        tbl[5] = '{3'd1, 8'd100, 1'b1, -16'sd1040};

        rst_n = 1'b0; tick = 1'b0; cur_we = 1'b0; cur_addr = 3'd0; cur_data = 8'd0; mon_addr = 3'd0;
        #12;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_spike_valid", longint'(spike_valid), 0);
        chk("rst_spike_vec", longint'(spike_vec), 0);
        chk("rst_overrun", longint'(overrun), 0);
        do_reset();
        for (int a = 0; a < 8; a++) begin
            read_v(3'(a), rv);
            chk($sformatf("rst_mon_v[%0d]", a), rv, -1040);
        end

        // Table: single neuron driven, one step each from reset
        for (int i = 0; i < 6; i++) begin
            do_reset();
            wr_cur(tbl[i].addr, tbl[i].cur);
            run_step(-1, -1, 3'd0, 8'd0, -1, bc, dc, sc, scyc, sid);
            chk($sformatf("busy_len[%0d]", i), bc, 24);
            chk($sformatf("done_cyc[%0d]", i), dc, 24);
            chk($sformatf("spike_cnt[%0d]", i), sc, longint'(tbl[i].exp_spike));
            if (tbl[i].exp_spike) begin
                chk($sformatf("spike_cyc[%0d]", i), scyc, 3 * longint'(tbl[i].addr) + 3);
                chk($sformatf("spike_id[%0d]", i), longint'(sid), longint'(tbl[i].addr));
            end
            chk($sformatf("spike_vec[%0d]", i), longint'(spike_vec),
                tbl[i].exp_spike ? (longint'(1) << tbl[i].addr) : 0);
            read_v(tbl[i].addr, rv);
            chk($sformatf("mon_v_hit[%0d]", i), rv, longint'(tbl[i].exp_v));
            read_v(tbl[i].addr + 3'd1, rv);
            chk($sformatf("mon_v_other[%0d]", i), rv, -1100);
        end

        // Write on neuron 3's LOAD edge keeps the old current for this step
        do_reset();
        wr_cur(3'd3, 8'd255);
        run_step(-1, 10, 3'd3, 8'd0, -1, bc, dc, sc, scyc, sid);
        chk("samecyc_spike_cnt", sc, 1);
        chk("samecyc_spike_cyc", scyc, 12);
        chk("samecyc_spike_vec", longint'(spike_vec), 8);
        run_step(-1, -1, 3'd0, 8'd0, -1, bc, dc, sc, scyc, sid);
        chk("samecyc_next_spike_cnt", sc, 0);
        chk("samecyc_next_vec", longint'(spike_vec), 0);
        read_v(3'd3, rv);
        chk("post_spike_v3", rv, -1228);
        read_v(3'd0, rv);
        chk("second_step_v0", rv, -1147);

        // Tick while busy: ignored, sticky overrun
        do_reset();
        chk("ovr_clear", longint'(overrun), 0);
        run_step(5, -1, 3'd0, 8'd0, -1, bc, dc, sc, scyc, sid);
        chk("ovr_busy_len", bc, 24);
        chk("ovr_done_cyc", dc, 24);
        chk("ovr_set", longint'(overrun), 1);
        run_step(-1, -1, 3'd0, 8'd0, -1, bc, dc, sc, scyc, sid);
        chk("ovr_sticky", longint'(overrun), 1);
        do_reset();
        chk("ovr_reset", longint'(overrun), 0);

        // Reset at cycle 10 aborts the step
        wr_cur(3'd3, 8'd255);
        run_step(-1, -1, 3'd0, 8'd0, 10, bc, dc, sc, scyc, sid);
        chk("abort_done", dc, -1);
        chk("abort_spike", sc, 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_vec", longint'(spike_vec), 0);
        read_v(3'd0, rv);
        chk("abort_v0", rv, -1040);
        read_v(3'd3, rv);
        chk("abort_v3", rv, -1040);
        run_step(-1, -1, 3'd0, 8'd0, -1, bc, dc, sc, scyc, sid);
        chk("after_abort_busy_len", bc, 24);
        chk("after_abort_done_cyc", dc, 24);
        chk("after_abort_spike", sc, 0);
        read_v(3'd3, rv);
        chk("after_abort_v3", rv, -1100);

        // Ten zero-current steps against the reference model
        do_reset();
        mv = -1040; mu = -260;
        for (int k = 0; k < 10; k++) begin
            run_step(-1, -1, 3'd0, 8'd0, -1, bc, dc, sc, scyc, sid);
            model_step(mv, mu, 0);
            chk($sformatf("iter_done[%0d]", k), dc, 24);
            read_v(3'(k % 8), rv);
            chk($sformatf("iter_v[%0d]", k), rv, mv);
        end
        for (int a = 0; a < 8; a++) begin
            read_v(3'(a), rv);
            chk($sformatf("iter_final_v[%0d]", a), rv, mv);
        end

        chk("idle_spike_id_zero", idle_id_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
